// File: rtl/angle_reducer.sv
// angle_reducer: reduces an unsigned whole-degree angle modulo FULL_CIRCLE by
// repeated subtraction, then maps it to a quadrant (0..3) and a reference
// angle (0..FULL_CIRCLE/4). The reference angle addresses a downstream
// quarter-wave LUT.
// The result is held until the LUT stage takes it with out_ready.
// Optional build macro: ANGLE_REDUCER_FAST_MOD_EN. When it is defined, the
// reducer subtracts 8*FULL_CIRCLE in one step while the accumulator is large
// enough. This only shortens latency for large inputs. The results are the
// same in both builds.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module angle_reducer #(
    parameter int unsigned FULL_CIRCLE = 360
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`DATA_WIDTH-1:0] angle_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             quadrant,
    output logic [`DATA_WIDTH-1:0] ref_angle
);

    localparam int unsigned W = `DATA_WIDTH;

    // Quadrant boundaries, all derived from the circle size.
    localparam logic [W-1:0] CIRCLE  = W'(FULL_CIRCLE);
    localparam logic [W-1:0] QUARTER = W'(FULL_CIRCLE / 4);
    localparam logic [W-1:0] HALF    = W'(FULL_CIRCLE / 2);
    localparam logic [W-1:0] THREE_Q = W'((3 * FULL_CIRCLE) / 4);
`ifdef ANGLE_REDUCER_FAST_MOD_EN
    localparam logic [W-1:0] BIG_STEP = W'(8 * FULL_CIRCLE);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MAP    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [1:0]     quadrant_q, quadrant_d;
    logic [W-1:0]   ref_q, ref_d;

    // State register; reset discards any in-flight angle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, reduce until below one circle, map, hold for handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = REDUCE;
            // Any subtraction step leaves us in REDUCE. A fast step can only
            // happen when acc_q >= CIRCLE, so this test covers both builds.
            REDUCE:  if (acc_q < CIRCLE) state_d = MAP;
            MAP:     state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake flags depend on the current state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
    end

    // Datapath next-state: latch the angle, do one subtraction per cycle, then map to a quadrant.
    always_comb begin
        acc_d      = acc_q;
        quadrant_d = quadrant_q;
        ref_d      = ref_q;
        case (state_q)
            IDLE: begin
                if (in_valid) acc_d = angle_in;
            end
            REDUCE: begin
                // Subtract only when acc_q >= subtrahend, so acc never wraps.
`ifdef ANGLE_REDUCER_FAST_MOD_EN
                if (acc_q >= BIG_STEP) begin
                    acc_d = acc_q - BIG_STEP;
                end else if (acc_q >= CIRCLE) begin
                    acc_d = acc_q - CIRCLE;
                end
`else
                if (acc_q >= CIRCLE) begin
                    acc_d = acc_q - CIRCLE;
                end
`endif
            end
            MAP: begin
                // Each boundary angle belongs to the lower quadrant, so ref never exceeds QUARTER.
                if (acc_q <= QUARTER) begin
                    quadrant_d = 2'd0;
                    ref_d      = acc_q;
                end else if (acc_q <= HALF) begin
                    quadrant_d = 2'd1;
                    ref_d      = HALF - acc_q;
                end else if (acc_q <= THREE_Q) begin
                    quadrant_d = 2'd2;
                    ref_d      = acc_q - HALF;
                end else begin
                    quadrant_d = 2'd3;
                    ref_d      = CIRCLE - acc_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; results stay put through HOLD because only MAP updates them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            quadrant_q <= 2'd0;
            ref_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            quadrant_q <= quadrant_d;
            ref_q      <= ref_d;
        end
    end

    assign quadrant  = quadrant_q;
    assign ref_angle = ref_q;

endmodule

// File: tb/tb_angle_reducer.sv
// tb_angle_reducer: self-checking bench for angle_reducer. Expected results
// come from a plain arithmetic model: angle mod 360, then a quadrant fold.
// Expected latency is the number of subtractions plus two.

`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_angle_reducer;

    localparam int W = `DATA_WIDTH;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   angle_in;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     quadrant;
    logic [W-1:0]   ref_angle;

    int n_checks = 0;
    int n_fails  = 0;

    angle_reducer #(.FULL_CIRCLE(360)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quadrant  (quadrant),
        .ref_angle (ref_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: fold the angle into one circle, then pick the quadrant.
    function automatic void model(input int a, output int q, output int r);
        int m;
        m = a % 360;
        if (m <= 90) begin
            q = 0; r = m;
        end else if (m <= 180) begin
            q = 1; r = 180 - m;
        end else if (m <= 270) begin
            q = 2; r = m - 180;
        end else begin
            q = 3; r = 360 - m;
        end
    endfunction

    function automatic int model_latency(input int a);
`ifdef ANGLE_REDUCER_FAST_MOD_EN
        return a / 2880 + (a % 2880) / 360 + 2;
`else
        return a / 360 + 2;
`endif
    endfunction

    // Send one angle, then measure latency and check the result.
    // The result is held for hold_cycles with out_ready low before release.
    task automatic run_angle(input int a, input int hold_cycles);
        int q, r, lat, exp_lat;
        model(a, q, r);
        exp_lat = model_latency(a);
        out_ready = (hold_cycles == 0);
        in_valid  = 1'b1;
        angle_in  = W'(a);
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        angle_in = W'($urandom_range(0, 4000));
        lat = 0;
        do begin
            check("in_ready_busy", int'(in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
        end else begin
            check($sformatf("latency_%0d", a), lat, exp_lat);
            check($sformatf("quadrant_%0d", a), int'(quadrant), q);
            check($sformatf("ref_%0d", a), int'(ref_angle), r);
            check("ref_le_90", int'(ref_angle <= 90), 1);
            for (int i = 0; i < hold_cycles; i++) begin
                in_valid = 1'b1;
                @(posedge clk); #1;
                check("hold_valid", int'(out_valid), 1);
                check("hold_quadrant", int'(quadrant), q);
                check("hold_ref", int'(ref_angle), r);
                check("hold_in_ready", int'(in_ready), 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            check("released_valid", int'(out_valid), 0);
            check("released_in_ready", int'(in_ready), 1);
        end
        $display("angle %0d -> q%0d ref %0d latency %0d hold %0d", a, quadrant, ref_angle, lat, hold_cycles);
    endtask

    initial begin
        int fixed_angles[8] = '{45, 135, 225, 315, 360, 450, 3000, 359};
        int q, r, seen;

        in_valid  = 1'b0;
        angle_in  = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_quadrant", int'(quadrant), 0);
        check("reset_ref", int'(ref_angle), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", int'(in_ready), 1);

        // Directed angles, including the 3000-degree case.
        foreach (fixed_angles[i]) run_angle(fixed_angles[i], 0);

        // Stall in HOLD for 5 cycles.
        run_angle(200, 5);

        // Boundary angles.
        run_angle(0, 0);
        run_angle(90, 0);
        run_angle(180, 0);
        run_angle(270, 0);

        // Abort an in-flight angle with an asynchronous reset in REDUCE.
        run_angle(135, 0);   // leaves nonzero quadrant/ref registered
        in_valid = 1'b1;
        angle_in = W'(1000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;  // now in REDUCE
        reset = 1'b1;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_quadrant", int'(quadrant), 0);
        check("abort_ref", int'(ref_angle), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("abort_no_out_valid", seen, 0);
        $display("reset abort of angle 1000 done");
        run_angle(90, 0);

        // Back-to-back sweep of one full circle.
        for (int a = 0; a < 360; a++) run_angle(a, 0);

        // Random angles with random stalls.
        for (int i = 0; i < 150; i++) begin
            run_angle(int'($urandom_range(0, 4000)), int'($urandom_range(0, 3)));
        end

        model(0, q, r);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/angle_reducer.md
ANGLE_REDUCER -- requirements
Module: angle_reducer

Interface
REQ-001 SHALL have parameter FULL_CIRCLE, default 360, meaning degrees per revolution (quarter = FULL_CIRCLE/4).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  angle_in valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an angle this cycle.
REQ-006 SHALL have port angle_in  input  `DATA_WIDTH  unsigned angle in whole degrees.
REQ-007 SHALL have port out_valid  output  1  quadrant/ref_angle valid; drives the LUT enable downstream.
REQ-008 SHALL have port out_ready  input  1  downstream LUT stage consumes the result.
REQ-009 SHALL have port quadrant  output  2  quadrant 0..3 of the reduced angle.
REQ-010 SHALL have port ref_angle  output  `DATA_WIDTH  reference angle 0..90, the LUT address.

Function
REQ-011 SHALL implement FSM states IDLE, REDUCE, MAP, HOLD.
REQ-012 IDLE: in_ready=1; on in_valid, SHALL latch angle_in into accumulator acc and go to REDUCE.
REQ-013 in_ready SHALL be 0 in REDUCE, MAP and HOLD; in_valid there is ignored and nothing is latched.
REQ-014 REDUCE: if acc >= FULL_CIRCLE, SHALL set acc <= acc - FULL_CIRCLE and stay; otherwise SHALL go to MAP.
REQ-015 MAP: with a = acc, SHALL register q0/ref=a for a<=90; q1/ref=180-a for 90<a<=180; q2/ref=a-180 for 180<a<=270; q3/ref=360-a for a>270; then go to HOLD.
REQ-016 Boundaries: a=0 -> q0/0; a=90 -> q0/90; a=180 -> q1/0; a=270 -> q2/90; a=359 -> q3/1.
REQ-017 HOLD: out_valid=1 and quadrant/ref_angle SHALL remain stable until out_ready=1; on that edge SHALL go to IDLE with out_valid=0.
REQ-018 Latency: with k = number of REDUCE subtractions, out_valid SHALL rise on the (k+2)th rising edge after the accept edge (2 for angle_in < 360).
REQ-019 Throughput: a new angle SHALL be accepted no earlier than the cycle after the HOLD handshake; no result is dropped or overwritten.
REQ-020 All arithmetic SHALL be unsigned at `DATA_WIDTH; acc never underflows, because subtraction occurs only when acc >= subtrahend.
REQ-021 out_valid SHALL be 1 only in HOLD.

Reset
REQ-022 On reset=1, SHALL immediately enter IDLE with acc=0, quadrant=0, ref_angle=0, out_valid=0, in_ready=1 after release.
REQ-023 Reset in REDUCE, MAP or HOLD SHALL discard the in-flight angle; no out_valid SHALL follow.

Configuration
REQ-024 Macro ANGLE_REDUCER_FAST_MOD_EN: when defined, REDUCE SHALL subtract 8*FULL_CIRCLE (2880) when acc >= 2880, else FULL_CIRCLE, one subtraction per cycle.
REQ-025 Without ANGLE_REDUCER_FAST_MOD_EN, REDUCE SHALL subtract only FULL_CIRCLE per cycle; results are identical in both builds, only latency differs.

Verification
REQ-026 angle_in=45, out_ready=1 -> q0, ref 45, out_valid on 2nd edge after accept, one cycle wide.
REQ-027 angle_in=135 / 225 / 315 -> q1/45, q2/45, q3/45; angle_in=360 -> q0/0; angle_in=450 -> q0/90, latency 3.
REQ-028 angle_in=200 with out_ready=0 for 5 cycles -> out_valid high, q2/20 held stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-029 angle_in=3000: without macro -> q1/60 at latency 10; with ANGLE_REDUCER_FAST_MOD_EN -> q1/60 at latency 3.
REQ-030 angle_in=1000, reset asserted in REDUCE -> outputs zero at once, no out_valid; next angle_in=90 -> q0/90 normally.
REQ-031 Sweep angle_in 0..359 back-to-back -> each quadrant/ref_angle matches REQ-015; ref_angle never exceeds 90.
